radix4_booth_multiplier: RTL
============================

Name: radix4_booth_multiplier

Overview:
Sequential radix-4 (modified Booth) integer multiplier. It is the multiply counterpart of the team's radix-4 SRT divider and shares the same start/done/signedInput handshake, so both sit side by side in the integer execution unit. It retires one Booth digit per cycle into a full 2N-bit product.

Parameters:
N, 32, operand width in bits; any N >= 4, odd N allowed.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  launch request; sampled only in IDLE or DONE.
signedInput  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
x  input  N  multiplicand; sampled with start.
y  input  N  multiplier; sampled with start.
p  output  2N  product; valid while done=1.
busy  output  1  high in RUN.
done  output  1  high in DONE.

Behaviour:
- Clock/reset: one clock (clk); reset (rst) is synchronous and active-high. rst has priority over all other inputs.
- Reset values: state=IDLE, p=0, busy=0, done=0, counter=0, internal registers=0.
- States and transitions:
  - IDLE: on start=1, latch operands and go to RUN with counter=0. Otherwise stay.
  - RUN: retire one digit per cycle. After the last digit, write p, set done=1 and go to DONE.
  - DONE: hold p and done. On start=1, behave exactly as IDLE+start (clear done, latch, go to RUN). Otherwise stay.
- Start is ignored in RUN; an in-flight operation is never disturbed.
- Operand extension: multiplier y is extended to W = 2*ITER bits, where ITER = N/2 + 1 (integer division).
  - Extension uses sign-extension if signedInput=1, zero-extension otherwise.
  - Append an implicit 0 below the LSB.
  - Multiplicand is extended to N+2 bits the same way.
- Digit recoding: each cycle takes the 3-bit window {y[2i+1], y[2i], y[2i-1]} and maps it to d in {-2,-1,0,+1,+2}:
  - 000, 111 -> 0
  - 001, 010 -> +1
  - 011 -> +2
  - 100 -> -2
  - 101, 110 -> -1
- Partial products: -1 and -2 are formed as the inverted operand plus carry-in (no separate negate).
- Accumulator: the accumulator is 2N+3 bits, arithmetic-shifted right by 2 per digit, and the final value is truncated to 2N bits.
- Latency: done rises exactly ITER edges after the edge that sampled start (N=32: 17, N=8: 5, N=7: 4). Throughput: one operation per ITER+1 cycles.
- Product rules:
  - Signed mode: p = x*y as 2N-bit two's complement. -2^(N-1) * -2^(N-1) is exact (2^(2N-2)).
  - Unsigned mode: p = x*y exact.
- Reset mid-RUN: abort immediately, return to reset values, no partial p visible.
- p is updated only on the RUN->DONE edge; it is stable during RUN and while in DONE.

Optional Feature:
Macro: MUL_ZERO_BYPASS_EN.
- Defined: if x==0 or y==0 when start is sampled, skip RUN. The next edge enters DONE with p=0 and done=1 (latency 1), and busy never asserts.
- Not defined: zero operands take the full ITER-cycle path and yield p=0.
- Both builds produce identical p for all inputs.

Test Plan:
- Reset, then N=32, signedInput=0, x=0xFFFFFFFF, y=0xFFFFFFFF, start 1 cycle -> done after 17 edges, p=0xFFFFFFFE00000001, busy high for 17 cycles.
- N=32, signedInput=1, x=0x80000000, y=0x80000000 -> p=0x4000000000000000; then x=-3 (0xFFFFFFFD), y=7 -> p=0xFFFFFFFFFFFFFFEB.
- N=32, signedInput=1, start held high continuously: operand pairs presented on each DONE cycle -> back-to-back results every 18 cycles, start pulses during RUN ignored.
- N=7 (odd), unsigned x=127, y=127 -> p=16129 after 4 edges; signed x=-64, y=-64 -> p=4096.
- Assert rst at RUN cycle 5 -> next edge p=0, done=0, busy=0, state IDLE; a fresh start with x=6, y=7 -> p=42.
- x=0, y=0x1234: with MUL_ZERO_BYPASS_EN -> done after 1 edge, p=0; without it -> done after 17 edges, p=0.

Source files
------------

// File: rtl/radix4_booth_multiplier.sv
// Sequential radix-4 (modified Booth) multiplier: one Booth digit per clock into a 2N-bit product.
// Optional feature macro: MUL_ZERO_BYPASS_EN (zero operand finishes on the launch edge, never enters RUN).
module radix4_booth_multiplier #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           signedInput,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic [2*N-1:0] p,
    output logic           busy,
    output logic           done
);
    localparam int ITER  = N/2 + 1;
    localparam int W     = 2*ITER;
    localparam int L     = W - 2;
    localparam int ACC_W = 2*N + 3;
    localparam int PP_W  = ACC_W - L;
    localparam int CNT_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N+1:0]     xe_q, xe_d;
    logic [W:0]       y_q, y_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [2*N-1:0]   p_q, p_d;

    logic             sx, sy, zero_op;
    logic             nz, two, neg;
    logic [PP_W-1:0]  xe_ext, mag, pp;
    logic [ACC_W-1:0] acc_shift, acc_step;

    assign sx = signedInput & x[N-1];
    assign sy = signedInput & y[N-1];

`ifdef MUL_ZERO_BYPASS_EN
    assign zero_op = (x == '0) || (y == '0);
`else
    assign zero_op = 1'b0;
`endif

    // Booth window sits in the low three bits of y_q; y_q shifts right two per digit.
    always_comb begin
        nz  = 1'b0;
        two = 1'b0;
        neg = 1'b0;
        case (y_q[2:0])
            3'b001, 3'b010: nz = 1'b1;
            3'b011: begin
                nz  = 1'b1;
                two = 1'b1;
            end
            3'b100: begin
                nz  = 1'b1;
                two = 1'b1;
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                nz  = 1'b1;
                neg = 1'b1;
            end
            default: ;
        endcase
    end

    assign xe_ext = {{(PP_W-N-2){xe_q[N+1]}}, xe_q};
    assign mag    = !nz ? '0 : (two ? (xe_ext << 1) : xe_ext);
    assign pp     = neg ? ~mag : mag;

    // Previous sum shifts down first, so the digit lands at bit L and the last digit needs no shift.
    assign acc_shift = $signed(acc_q) >>> 2;
    assign acc_step  = acc_shift + {pp, {L{1'b0}}} + {{(PP_W-1){1'b0}}, neg, {L{1'b0}}};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xe_d    = xe_q;
        y_d     = y_q;
        acc_d   = acc_q;
        p_d     = p_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (zero_op) begin
                        state_d = S_DONE;
                        p_d     = '0;
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        xe_d    = {{2{sx}}, x};
                        y_d     = {{(W-N){sy}}, y, 1'b0};
                        acc_d   = '0;
                    end
                end
            end
            S_RUN: begin
                acc_d = acc_step;
                y_d   = {y_q[W], y_q[W], y_q[W:2]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    p_d     = acc_step[2*N-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            xe_q    <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xe_q    <= xe_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
        end
    end

    assign p    = p_q;
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
endmodule
